// File: rtl/sevenseg_readback.sv
// sevenseg_readback: debounce a seven-segment bus and decode the accepted pattern back to hex
module sevenseg_readback #(
    parameter int STABLE_CYCLES = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       seg_in,
    output logic [3:0]       digit,
    output logic             dp,
    output logic             blank,
    output logic             invalid,
    output logic             valid,
    output logic             stable,
    output logic [CNT_W-1:0] update_count
);
    typedef enum logic [1:0] {IDLE, SETTLING, LOCKED} state_t;
    // Acceptance fires on the edge that takes the settle counter to STABLE_CYCLES-1
    localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 2);
    state_t state, state_nx;
    logic [7:0] samp, samp_prev, acc, cnt;
    logic [3:0] hex;
    logic eq, accept, hit;
    assign eq = samp == samp_prev;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // Next state: disable wins, any sample change restarts settling, full count locks
    always_comb begin
        state_nx = state;
        accept = 1'b0;
        if (!en) state_nx = IDLE;
        else if (state == IDLE || !eq) state_nx = SETTLING;
        else if (state == SETTLING && cnt == LAST) begin
            state_nx = LOCKED;
            accept = 1'b1;
        end
    end
    // Outputs of the FSM
    always_comb stable = state == LOCKED && samp == acc;
    // Sampling, settle counting, accepted-pattern capture and the saturating update counter
    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= '0;
            samp_prev <= '0;
            cnt <= '0;
            acc <= '0;
            valid <= 1'b0;
            update_count <= '0;
        end else begin
            samp <= seg_in;
            samp_prev <= samp;
            cnt <= (en && state == SETTLING && eq) ? cnt + 8'd1 : '0;
            valid <= accept && samp != acc;
            if (accept && samp != acc) begin
                acc <= samp;
                if (~&update_count) update_count <= update_count + 1'b1;
            end
        end
    end
    // Decode the accepted a..g pattern; dp plays no part in the digit
    always_comb begin
        hit = 1'b1;
        hex = 4'h0;
        case (acc[6:0])
            7'h3F: hex = 4'h0;
            7'h06: hex = 4'h1;
            7'h5B: hex = 4'h2;
            7'h4F: hex = 4'h3;
            7'h66: hex = 4'h4;
            7'h6D: hex = 4'h5;
            7'h7D: hex = 4'h6;
            7'h07: hex = 4'h7;
            7'h7F: hex = 4'h8;
            7'h6F: hex = 4'h9;
            7'h77: hex = 4'hA;
            7'h7C: hex = 4'hB;
            7'h39: hex = 4'hC;
            7'h5E: hex = 4'hD;
            7'h79: hex = 4'hE;
            7'h71: hex = 4'hF;
            default: hit = 1'b0;
        endcase
    end
    assign digit = hit ? hex : 4'h0;
    assign dp = acc[7];
    assign blank = acc[6:0] == 7'h00;
    assign invalid = !hit && !blank;
endmodule

// File: tb/tb_sevenseg_readback.sv
// tb_sevenseg_readback: randomized scoreboard bench against a run-length reference model
module tb_sevenseg_readback;
    localparam int S = 4;
    localparam int CW = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic [7:0] seg_in = 8'h00;
    logic [3:0] digit;
    logic dp, blank, invalid, valid, stable;
    logic [CW-1:0] update_count;

    sevenseg_readback #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .digit(digit), .dp(dp),
        .blank(blank), .invalid(invalid), .valid(valid), .stable(stable),
        .update_count(update_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        logic [3:0] digit;
        logic dp, blank, invalid;
        logic [CW-1:0] cnt;
    } exp_t;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [7:0] pool [6] = '{8'h3F, 8'h5B, 8'hDB, 8'h00, 8'h49, 8'h71};

    exp_t q[$];
    int checks = 0;
    int fails = 0;

    // Reference model state: edge number, run length of identical samples, enabled-edge run
    int cyc = 0;
    int run = 1;
    int en_len = 0;
    logic [7:0] val = 8'h00;
    logic [7:0] m_acc = 8'h00;
    int m_cnt = 0;
    bit m_cond = 1'b0;
    bit m_stable = 1'b0;

    function automatic exp_t dec(logic [7:0] p, int c);
        exp_t e;
        e.cyc = 0;
        e.digit = 4'h0;
        e.dp = p[7];
        e.blank = p[6:0] == 7'h00;
        e.invalid = !e.blank;
        e.cnt = CW'(c);
        for (int i = 0; i < 16; i++)
            if (tbl[i] == p[6:0]) begin
                e.digit = 4'(i);
                e.invalid = 1'b0;
            end
        return e;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, cyc);
        end
    endtask

    // A pattern is accepted once it has been sampled S times in a row and the block has
    // been enabled for the last S edges; the accepted value is the previous sample.
    always @(posedge clk) begin
        int pr;
        logic [7:0] pv;
        bit cond;
        exp_t e;
        cyc++;
        if (rst) begin
            val = 8'h00;
            run = 1;
            en_len = 0;
            m_acc = 8'h00;
            m_cnt = 0;
            m_cond = 1'b0;
            m_stable = 1'b0;
        end else begin
            pr = run;
            pv = val;
            run = (seg_in == val) ? ((run < 1000) ? run + 1 : run) : 1;
            val = seg_in;
            en_len = en ? en_len + 1 : 0;
            cond = pr >= S && en_len >= S;
            if (cond && !m_cond && pv != m_acc) begin
                m_acc = pv;
                if (m_cnt < 2 ** CW - 1) m_cnt++;
                e = dec(pv, m_cnt);
                e.cyc = cyc;
                q.push_back(e);
            end
            m_cond = cond;
            m_stable = cond && val == m_acc;
        end
    end

    // Monitor: pops the scoreboard on each valid pulse, flags missing pulses, checks held outputs
    always @(negedge clk) begin
        exp_t e;
        exp_t h;
        if (cyc > 0) begin
            if (valid) begin
                if (q.size() == 0) cmp("unexpected_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    cmp("valid_edge", cyc, e.cyc);
                    cmp("valid_outputs", int'({digit, dp, blank, invalid, update_count}),
                        int'({e.digit, e.dp, e.blank, e.invalid, e.cnt}));
                end
            end else if (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                cmp("missing_valid", 0, 1);
            end
            h = dec(m_acc, m_cnt);
            cmp("held_outputs", int'({digit, dp, blank, invalid, update_count}),
                int'({h.digit, h.dp, h.blank, h.invalid, h.cnt}));
            cmp("stable", int'(stable), int'(m_stable));
        end
    end

    task automatic drive(input logic [7:0] p, input bit e, input int n);
        seg_in = p;
        en = e;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset();
        cmp("reset_outputs", int'({digit, dp, blank, invalid, valid, stable, update_count}),
            int'({4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {CW{1'b0}}}));
    endtask

    initial begin
        rst = 1'b1;
        drive(8'h00, 1'b0, 3);
        check_reset();
        rst = 1'b0;
        drive(8'h00, 1'b1, 20);
        drive(8'h5B, 1'b1, 10);
        drive(8'h06, 1'b1, 2);
        drive(8'h5B, 1'b1, 10);
        drive(8'hDB, 1'b1, 10);
        drive(8'h49, 1'b1, 10);
        drive(8'h7F, 1'b1, 2);
        drive(8'h7F, 1'b0, 10);
        drive(8'h7F, 1'b1, 10);
        drive(8'h06, 1'b1, 2);
        rst = 1'b1;
        drive(8'h06, 1'b1, 1);
        check_reset();
        rst = 1'b0;
        drive(8'h3F, 1'b1, 8);
        drive(8'h06, 1'b1, 8);
        drive(8'h5B, 1'b1, 8);
        drive(8'h4F, 1'b1, 8);
        drive(8'h66, 1'b1, 8);
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] p;
            p = ($urandom_range(0, 5) < 5) ? pool[$urandom_range(0, 5)] : 8'($urandom);
            rst = $urandom_range(0, 99) == 0;
            drive(p, $urandom_range(0, 9) != 0, $urandom_range(1, 8));
            rst = 1'b0;
        end
        drive(seg_in, 1'b1, 12);
        cmp("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
